// File: rtl/mii_frame_generator.sv
`default_nettype none
// ============================================================================
// Module   : mii_frame_generator
// Purpose  : Transmit-side frame source for a 64-bit, 8-lane MII-style link.
//            A start request emits one frame: a START word, len>>3 full DATA
//            words, and a TERM word carrying the len&7 trailing bytes. The
//            frame is followed by max(ipg,1) all-IDLE gap cycles. Payload
//            byte n is (seed + n) mod 256, so the far end can check both
//            length and content.
// Ports    : clk            - clock
//            i_rst          - synchronous reset, active-high
//            i_start        - frame request, taken when i_start && o_ready
//            i_payload_len  - payload byte count, latched at accept
//            i_seed         - first payload byte, latched at accept
//            i_ipg_cycles   - gap cycles after TERM (0 acts as 1)
//            o_ready        - a request can be accepted this cycle
//            o_tx_data      - lane data, lane k = bits [8k+7:8k]
//            o_tx_ctrl      - per-lane control flag
//            o_frame_done   - one-cycle pulse alongside the TERM word
//            o_frame_count  - completed frames, wraps at 16 bits
// Revision : 1.0 - initial release
// ============================================================================
module mii_frame_generator #(
    parameter int         DATA_WIDTH = 64,
    parameter int         CTRL_WIDTH = 8,
    parameter logic [7:0] IDLE_CODE  = 8'h07,
    parameter logic [7:0] START_CODE = 8'hFB,
    parameter logic [7:0] TERM_CODE  = 8'hFD,
    parameter int         LEN_WIDTH  = 8,
    parameter int         IPG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [LEN_WIDTH-1:0]  i_payload_len,
    input  logic [7:0]            i_seed,
    input  logic [IPG_WIDTH-1:0]  i_ipg_cycles,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
    output logic                  o_frame_done,
    output logic [15:0]           o_frame_count
);

    localparam int c_WORD_W = LEN_WIDTH - 3;

    // The state names the word currently presented on o_tx_*.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_TERM  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                r_state_q, w_state_d;
    logic [c_WORD_W-1:0]   r_words_q, w_words_d;   // DATA words still to send
    logic [2:0]            r_rem_q,   w_rem_d;     // bytes carried by TERM
    logic [7:0]            r_byte_q,  w_byte_d;    // next payload byte value
    logic [IPG_WIDTH-1:0]  r_ipg_q,   w_ipg_d;
    logic [IPG_WIDTH-1:0]  r_gap_q,   w_gap_d;     // gap cycles left, incl. current
    logic [DATA_WIDTH-1:0] r_data_q,  w_data_d;
    logic [CTRL_WIDTH-1:0] r_ctrl_q,  w_ctrl_d;
    logic                  r_done_q,  w_done_d;
    logic [15:0]           r_count_q, w_count_d;
    logic                  w_last_gap;
    logic                  w_accept;

    assign w_last_gap = (r_state_q == S_GAP) && (r_gap_q == IPG_WIDTH'(1));
    // Gating with i_rst keeps ready low for the whole reset window, including
    // its first cycle, while the state itself already reads as IDLE.
    assign o_ready    = !i_rst && ((r_state_q == S_IDLE) || w_last_gap);
    assign w_accept   = i_start && o_ready;

    always_comb begin
        w_state_d = r_state_q;
        w_words_d = r_words_q;
        w_rem_d   = r_rem_q;
        w_byte_d  = r_byte_q;
        w_ipg_d   = r_ipg_q;
        w_gap_d   = r_gap_q;
        w_data_d  = {CTRL_WIDTH{IDLE_CODE}};
        w_ctrl_d  = '1;
        w_done_d  = 1'b0;
        w_count_d = r_count_q;

        case (r_state_q)
            S_IDLE: begin
                if (w_accept) w_state_d = S_START;
            end
            S_START, S_DATA: begin
                w_state_d = (r_words_q != '0) ? S_DATA : S_TERM;
            end
            S_TERM: begin
                w_state_d = S_GAP;
                w_gap_d   = (r_ipg_q == '0) ? IPG_WIDTH'(1) : r_ipg_q;
            end
            S_GAP: begin
                if (w_last_gap) w_state_d = w_accept ? S_START : S_IDLE;
                else            w_gap_d   = r_gap_q - IPG_WIDTH'(1);
            end
            default: w_state_d = S_IDLE;
        endcase

        if (w_accept) begin
            w_words_d = i_payload_len[LEN_WIDTH-1:3];
            w_rem_d   = i_payload_len[2:0];
            w_byte_d  = i_seed;
            w_ipg_d   = i_ipg_cycles;
        end

        // Build the word for the state being entered; it appears next cycle.
        case (w_state_d)
            S_START: begin
                w_ctrl_d = '0;
                w_ctrl_d[0] = 1'b1;
                for (int k = 0; k < CTRL_WIDTH; k++) begin
                    if (k == 0)                   w_data_d[8*k +: 8] = START_CODE;
                    else if (k == CTRL_WIDTH - 1) w_data_d[8*k +: 8] = 8'hD5;
                    else                          w_data_d[8*k +: 8] = 8'h55;
                end
            end
            S_DATA: begin
                w_ctrl_d = '0;
                for (int k = 0; k < CTRL_WIDTH; k++) begin
                    w_data_d[8*k +: 8] = r_byte_q + 8'(k);
                end
                w_byte_d  = r_byte_q + 8'(CTRL_WIDTH);
                w_words_d = r_words_q - c_WORD_W'(1);
            end
            S_TERM: begin
                for (int k = 0; k < CTRL_WIDTH; k++) begin
                    if (k < int'(r_rem_q)) begin
                        w_data_d[8*k +: 8] = r_byte_q + 8'(k);
                        w_ctrl_d[k]        = 1'b0;
                    end else if (k == int'(r_rem_q)) begin
                        w_data_d[8*k +: 8] = TERM_CODE;
                    end
                end
                w_done_d  = 1'b1;
                w_count_d = r_count_q + 16'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state_q <= S_IDLE;
            r_words_q <= '0;
            r_rem_q   <= '0;
            r_byte_q  <= '0;
            r_ipg_q   <= '0;
            r_gap_q   <= '0;
            r_data_q  <= {CTRL_WIDTH{IDLE_CODE}};
            r_ctrl_q  <= '1;
            r_done_q  <= 1'b0;
            r_count_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_words_q <= w_words_d;
            r_rem_q   <= w_rem_d;
            r_byte_q  <= w_byte_d;
            r_ipg_q   <= w_ipg_d;
            r_gap_q   <= w_gap_d;
            r_data_q  <= w_data_d;
            r_ctrl_q  <= w_ctrl_d;
            r_done_q  <= w_done_d;
            r_count_q <= w_count_d;
        end
    end

    assign o_tx_data     = r_data_q;
    assign o_tx_ctrl     = r_ctrl_q;
    assign o_frame_done  = r_done_q;
    assign o_frame_count = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mii_frame_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mii_frame_generator
// Purpose  : Self-checking bench for mii_frame_generator. A frame-level model
//            expands each request into the per-cycle word stream the link
//            must carry; a compare process checks every cycle against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mii_frame_generator;

    localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
    localparam logic [63:0] START_W = 64'hD5555555555555FB;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_payload_len = '0;
    logic [7:0]  i_seed = '0;
    logic [3:0]  i_ipg_cycles = '0;
    logic        o_ready;
    logic [63:0] o_tx_data;
    logic [7:0]  o_tx_ctrl;
    logic        o_frame_done;
    logic [15:0] o_frame_count;

    mii_frame_generator dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_payload_len (i_payload_len),
        .i_seed        (i_seed),
        .i_ipg_cycles  (i_ipg_cycles),
        .o_ready       (o_ready),
        .o_tx_data     (o_tx_data),
        .o_tx_ctrl     (o_tx_ctrl),
        .o_frame_done  (o_frame_done),
        .o_frame_count (o_frame_count)
    );

    always #5 clk = ~clk;

    // Expected per-cycle outputs and the stimulus driven in that cycle.
    logic [63:0] e_data[$];
    logic [7:0]  e_ctrl[$];
    logic        e_done[$];
    logic        e_ready[$];
    logic [15:0] e_cnt[$];
    logic        s_start[$];
    logic [7:0]  s_len[$];
    logic [7:0]  s_seed[$];
    logic [3:0]  s_ipg[$];

    int m_cnt  = 0;
    int n_cmp  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push(input logic [63:0] d, input logic [7:0] c,
                                 input logic done, input logic rdy);
        e_data.push_back(d);
        e_ctrl.push_back(c);
        e_done.push_back(done);
        e_ready.push_back(rdy);
        e_cnt.push_back(16'(m_cnt));
        // Busy cycles get random requests that the DUT must ignore.
        s_start.push_back(rdy ? 1'b0 : 1'($urandom_range(0, 1)));
        s_len.push_back(8'($urandom));
        s_seed.push_back(8'($urandom));
        s_ipg.push_back(4'($urandom));
    endfunction

    function automatic void clear_model();
        e_data.delete(); e_ctrl.delete(); e_done.delete(); e_ready.delete();
        e_cnt.delete(); s_start.delete(); s_len.delete(); s_seed.delete();
        s_ipg.delete();
        m_cnt = 0;
        push(IDLE_W, 8'hFF, 1'b0, 1'b1);   // first cycle after reset release
    endfunction

    // Requires the last queued cycle to be a ready cycle.
    function automatic void add_frame(input int len, input int seed, input int ipg,
                                      input int wait_cycles, output int st, output int tm);
        int k, r, g;
        logic [63:0] d;
        logic [7:0]  c;
        for (int i = 0; i < wait_cycles; i++) push(IDLE_W, 8'hFF, 1'b0, 1'b1);
        k = s_start.size() - 1;
        s_start[k] = 1'b1;
        s_len[k]   = 8'(len);
        s_seed[k]  = 8'(seed);
        s_ipg[k]   = 4'(ipg);
        st = e_data.size();
        push(START_W, 8'h01, 1'b0, 1'b0);
        for (int w = 0; w < len / 8; w++) begin
            for (int b = 0; b < 8; b++) d[8*b +: 8] = 8'(seed + 8*w + b);
            push(d, 8'h00, 1'b0, 1'b0);
        end
        r = len % 8;
        d = IDLE_W;
        c = 8'hFF;
        for (int b = 0; b < r; b++) begin
            d[8*b +: 8] = 8'(seed + len - r + b);
            c[b] = 1'b0;
        end
        d[8*r +: 8] = 8'hFD;
        m_cnt = (m_cnt + 1) % 65536;
        tm = e_data.size();
        push(d, c, 1'b1, 1'b0);
        g = (ipg == 0) ? 1 : ipg;
        for (int i = 0; i < g; i++) push(IDLE_W, 8'hFF, 1'b0, (i == g - 1));
    endfunction

    function automatic void add_trailer();
        for (int i = 0; i < 3; i++) push(IDLE_W, 8'hFF, 1'b0, 1'b1);
    endfunction

    task automatic drive(input int c);
        i_start       = s_start[c];
        i_payload_len = s_len[c];
        i_seed        = s_seed[c];
        i_ipg_cycles  = s_ipg[c];
    endtask

    // Releases reset and plays the whole queued stream.
    task automatic run_stream();
        @(posedge clk); #1;
        i_rst = 1'b0;
        cyc = 0;
        drive(0);
        chk_en = 1'b1;
        for (int c = 1; c < e_data.size(); c++) begin
            @(posedge clk); #1;
            cyc = c;
            drive(c);
        end
        @(negedge clk); #1;
        chk_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk($sformatf("tx_data@%0d", cyc),     o_tx_data,     e_data[cyc]);
            chk($sformatf("tx_ctrl@%0d", cyc),     64'(o_tx_ctrl), 64'(e_ctrl[cyc]));
            chk($sformatf("frame_done@%0d", cyc),  64'(o_frame_done), 64'(e_done[cyc]));
            chk($sformatf("ready@%0d", cyc),       64'(o_ready),   64'(e_ready[cyc]));
            chk($sformatf("frame_count@%0d", cyc), 64'(o_frame_count), 64'(e_cnt[cyc]));
        end
    end

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_ready"}, 64'(o_ready),       64'd0);
        chk({tag, "_data"},  o_tx_data,          IDLE_W);
        chk({tag, "_ctrl"},  64'(o_tx_ctrl),     64'hFF);
        chk({tag, "_done"},  64'(o_frame_done),  64'd0);
        chk({tag, "_count"}, 64'(o_frame_count), 64'd0);
    endtask

    initial begin
        int st1, tm1, st2, tm2, st3, tm3, st4, tm4, st5, tm5, st, tm;

        // ---------------- Phase A: reset, directed + random frames --------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_reset("reset");

        clear_model();
        add_frame(40, 8'h00, 2, 0, st1, tm1);
        add_frame(43, 8'h10, 1, 2, st2, tm2);
        add_frame(0,  8'h99, 0, 1, st3, tm3);
        add_frame(7,  8'h20, 5, 0, st4, tm4);
        add_frame(8,  8'hFC, 3, 0, st5, tm5);
        for (int f = 0; f < 20; f++) begin
            add_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), st, tm);
        end
        add_trailer();

        // Hand-computed values that pin the model itself.
        chk("pin_start_idx",   64'(st1), 64'd1);
        chk("pin_start_word",  e_data[st1], 64'hD5555555555555FB);
        chk("pin_start_ctrl",  64'(e_ctrl[st1]), 64'h01);
        chk("pin_data0",       e_data[st1+1], 64'h0706050403020100);
        chk("pin_len40_words", 64'(tm1 - st1), 64'd6);
        chk("pin_len40_term",  e_data[tm1], 64'h07070707070707FD);
        chk("pin_len40_gap",   64'({e_ready[tm1+1], e_ready[tm1+2]}), 64'b01);
        chk("pin_len40_count", 64'(e_cnt[tm1+2]), 64'd1);
        chk("pin_len43_term",  e_data[tm2], 64'h07070707FD3A3938);
        chk("pin_len43_ctrl",  64'(e_ctrl[tm2]), 64'hF8);
        chk("pin_len0_term",   e_data[tm3], 64'h07070707070707FD);
        chk("pin_len0_adj",    64'(tm3 - st3), 64'd1);
        chk("pin_ipg0_gap",    64'(st4 - tm3 - 1), 64'd1);
        chk("pin_len7_term",   e_data[tm4], 64'hFD26252423222120);
        chk("pin_len7_ctrl",   64'(e_ctrl[tm4]), 64'h80);
        chk("pin_ipg5_gap",    64'(st5 - tm4 - 1), 64'd5);
        chk("pin_wrap_data",   e_data[st5+1], 64'h03020100FFFEFDFC);
        chk("pin_wrap_term",   e_data[tm5], 64'h07070707070707FD);

        run_stream();

        // ---------------- Phase B: reset in the 3rd DATA word -------------
        @(posedge clk); #1;
        i_start = 1'b1; i_payload_len = 8'd136; i_seed = 8'h40; i_ipg_cycles = 4'd2;
        @(negedge clk);
        chk("b_ready", 64'(o_ready), 64'd1);
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        chk("b_start", o_tx_data, START_W);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_data1", o_tx_data, 64'h4746454443424140);
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_rst = 1'b1;
        @(negedge clk);
        chk("b_data3", o_tx_data, 64'h5756555453525150);
        chk("b_data3_ready", 64'(o_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk_idle_reset($sformatf("midreset%0d", i));
        end

        clear_model();
        add_frame(136, 8'hA0, 2, 1, st, tm);
        chk("pin_len136_words", 64'(tm - st), 64'd18);
        chk("pin_len136_term",  e_data[tm], 64'h07070707070707FD);
        chk("pin_len136_count", 64'(e_cnt[tm]), 64'd1);
        for (int f = 0; f < 3; f++) begin
            add_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), st, tm);
        end
        add_trailer();
        run_stream();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mii_frame_generator.md
Name: mii_frame_generator

Overview:
- Transmit-side frame source for the 64-bit MII-style lane interface (8 byte lanes, 1 ctrl bit per lane), the driving end of the link the TX-stream checker monitors.
- On a start request it emits one frame: START cycle, payload words, terminate cycle. It then emits a programmable number of all-IDLE inter-frame gap cycles.
- The payload is a deterministic incrementing byte pattern so the receive/check side can verify length and content.

Parameters:
- DATA_WIDTH, 64, lane data width; fixed at 8 lanes × 8 bits.
- CTRL_WIDTH, 8, one ctrl bit per lane.
- IDLE_CODE, 8'h07, idle control character.
- START_CODE, 8'hFB, start control character, always in lane 0.
- TERM_CODE, 8'hFD, terminate control character.
- LEN_WIDTH, 8, width of the payload byte-count input.
- IPG_WIDTH, 4, width of the gap-cycle input.

Ports:
- clk  input  1  clock.
- i_rst  input  1  synchronous reset, active-high.
- i_start  input  1  frame request; accepted when i_start && o_ready.
- i_payload_len  input  LEN_WIDTH  payload bytes; latched at accept.
- i_seed  input  8  first payload byte value; latched at accept.
- i_ipg_cycles  input  IPG_WIDTH  all-IDLE cycles after the terminate cycle; latched at accept; 0 is treated as 1.
- o_ready  output  1  generator can accept a request this cycle.
- o_tx_data  output  DATA_WIDTH  lane data; lane k = bits [8k+7:8k].
- o_tx_ctrl  output  CTRL_WIDTH  bit k=1: lane k carries a control character.
- o_frame_done  output  1  one-cycle pulse, coincident with the terminate cycle on o_tx_*.
- o_frame_count  output  16  frames completed; wraps at 65535→0.

Behaviour:
- Reset (sync): state IDLE.
  - o_tx_data = {8{IDLE_CODE}}, o_tx_ctrl = 8'hFF.
  - o_ready = 0 while i_rst is high, 1 on the first cycle after release.
  - o_frame_done = 0, o_frame_count = 0.
- All outputs are registered. An accept in cycle N puts the START word on o_tx_* in cycle N+1.
- States: IDLE → START → DATA (skipped if len<8) → TERM → GAP → IDLE or START.
- IDLE: output all-IDLE. o_ready=1. On accept, latch len, seed and ipg, then go to START.
- START word: lane0 = START_CODE with ctrl=1. Lanes1..6 = 8'h55, lane7 = 8'hD5, all ctrl=0. Then go to DATA if len≥8, else TERM.
- DATA: emits len>>3 full words, ctrl=8'h00. Payload byte n = (seed+n) mod 256, lane 0 = lowest n of the word. A word counter counts down; on the last DATA word go to TERM.
- TERM word: r = len & 7.
  - Lanes 0..r-1 carry the final r payload bytes, ctrl=0.
  - Lane r = TERM_CODE, ctrl=1.
  - Lanes r+1..7 = IDLE_CODE, ctrl=1.
  - r=0 gives TERM in lane 0 and the rest IDLE.
  - o_frame_done=1 this cycle; o_frame_count increments.
- len=0: START word then immediately the TERM word with TERM in lane 0.
- GAP: outputs all-IDLE (ctrl=8'hFF) for G = max(ipg,1) cycles.
  - o_ready=1 only in the last GAP cycle.
  - Accept there goes to START, so back-to-back requests give exactly G IDLE cycles between TERM and START words.
  - Otherwise go to IDLE.
- o_ready=0 in START, DATA, TERM and non-final GAP cycles. i_start is ignored there, with no queuing.
- Latched len/seed/ipg are unaffected by input changes mid-frame.
- Reset mid-frame: the next cycle outputs all-IDLE with no TERM emitted. o_frame_done is not pulsed and o_frame_count clears to 0.
- Payload byte counter arithmetic is 8-bit wrapping (seed 8'hFE, n=3 → 8'h01).

Test Plan:
- Reset, then i_start with len=40, seed=8'h00, ipg=2 → one START word (8'hD5555555555555FB, ctrl 8'h01) one cycle after accept.
  - Then 5 DATA words; the first is 8'h0706050403020100, ctrl 8'h00.
  - Then TERM word 8'h07070707070707FD, ctrl 8'hFF, with o_frame_done=1.
  - Then 2 IDLE cycles; o_frame_count=1.
- len=43, seed=8'h10 → 5 DATA words, then TERM word with lanes0-2 = 8'h38,8'h39,8'h3A, lane3=FD, lanes4-7=07; ctrl 8'hF8.
- len=0 and len=7 → START immediately followed by TERM: ctrl 8'hFF (FD in lane0) and ctrl 8'h80 (FD in lane7) respectively.
- i_start held high, ipg=0 then ipg=5 → exactly 1 and 5 all-IDLE cycles between TERM and next START; o_ready high only in the final GAP cycle.
- seed=8'hFC, len=8 → DATA word bytes FC,FD,FE,FF,00,01,02,03 (wrap), followed by TERM in lane0.
- Assert i_rst during the 3rd DATA word of a 136-byte frame → next cycle all-IDLE/ctrl 8'hFF, o_frame_done never pulses, o_frame_count=0. After release a new request produces a complete frame.
